// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for one shared memory bus: one-hot registered grants held until
// the owner releases, a wait for memory Ready to fall, and an optional grant watchdog.
module bus_rr_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  localparam int unsigned OWNER_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] bus_rq,
  input  logic                   bus_mem_ready,
  output logic [NUM_MASTERS-1:0] bus_grant,
  output logic [OWNER_W-1:0]     bus_owner,
  output logic                   bus_busy,
  output logic                   timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    WAIT_MEM_LOW
  } state_e;

  localparam logic [15:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
  localparam logic [OWNER_W-1:0] LAST_INIT = OWNER_W'(NUM_MASTERS - 1);

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [OWNER_W-1:0]     last_q,  last_d;
  logic [15:0]            cnt_q,   cnt_d;
  logic                   pulse_q, pulse_d;

  logic                   found;
  logic [OWNER_W-1:0]     winner;
  logic [OWNER_W-1:0]     cand;
  logic                   owner_rq;

  // Search starts just after the last winner and wraps; an X request bit fails the
  // if-test and therefore never wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = OWNER_W'((32'(last_q) + k) % NUM_MASTERS);
      if (!found && bus_rq[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    owner_rq = 1'b0;
    if (bus_rq[owner_q]) begin
      owner_rq = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (found && !bus_mem_ready) begin
          grant_d = NUM_MASTERS'(1) << winner;
          owner_d = winner;
          last_d  = winner;
          cnt_d   = '0;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        // A release on the same edge as the watchdog limit is a normal release.
        if (!owner_rq) begin
          grant_d = '0;
          state_d = WAIT_MEM_LOW;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          grant_d = '0;
          pulse_d = 1'b1;
          state_d = WAIT_MEM_LOW;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_MEM_LOW: begin
        grant_d = '0;
        if (!bus_mem_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus_grant     = grant_q;
  assign bus_owner     = owner_q;
  assign bus_busy      = (state_q != IDLE);
  assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (4 masters, 8-cycle watchdog); expected grants are
// queued when requests are driven and popped when a grant appears.
module tb_bus_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rq = '0;
  logic       rdy = 1'b0;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       tpulse;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] owner;
  } exp_t;

  exp_t sb[$];

  bus_rr_arbiter #(.NUM_MASTERS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_rq        (rq),
    .bus_mem_ready (rdy),
    .bus_grant     (grant),
    .bus_owner     (owner),
    .bus_busy      (busy),
    .timeout_pulse (tpulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] o);
    exp_t e;
    e.grant = g;
    e.owner = o;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int exp_lat);
    int lat;
    exp_t e;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (grant == 4'b0000 && lat < 20);
    check("grant_arrived", 32'(grant != 4'b0000), 32'd1);
    check("grant_latency", 32'(lat), 32'(exp_lat));
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("grant_value", 32'(grant), 32'(e.grant));
      check("owner_value", 32'(owner), 32'(e.owner));
    end
  endtask

  task automatic apply_reset();
    rq = '0;
    rdy = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulse", 32'(tpulse), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;

    // 1: single core, release, busy drops once Ready is low
    apply_reset();
    rq = 4'b0010;
    push(4'b0010, 2'd1);
    wait_grant(1);
    check("t1_busy", 32'(busy), 32'd1);
    rq = 4'b0000;
    tick();
    check("t1_release_grant", 32'(grant), 32'd0);
    check("t1_wait_busy", 32'(busy), 32'd1);
    check("t1_owner_held", 32'(owner), 32'd1);
    tick();
    check("t1_idle_busy", 32'(busy), 32'd0);

    // X requests never win
    rq = 4'bxxxx;
    repeat (3) begin
      tick();
      check("x_no_grant", 32'(grant), 32'd0);
      check("x_no_busy", 32'(busy), 32'd0);
    end

    // 2: all requesting, order 0,1,2,3,0
    apply_reset();
    rq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      push(4'(1 << (i % 4)), 2'(i % 4));
      wait_grant(i == 0 ? 1 : 2);
      repeat (2) begin
        tick();
        check("t2_hold", 32'(grant), 32'(1 << (i % 4)));
      end
      rq[i % 4] = 1'b0;
      tick();
      check("t2_release", 32'(grant), 32'd0);
      rq[i % 4] = 1'b1;
    end

    // 3: Ready high blocks arbitration and holds WAIT_MEM_LOW
    apply_reset();
    rdy = 1'b1;
    rq = 4'b0001;
    repeat (3) begin
      tick();
      check("t3_blocked", 32'(grant), 32'd0);
    end
    rdy = 1'b0;
    push(4'b0001, 2'd0);
    wait_grant(1);
    rdy = 1'b1;
    rq = 4'b0000;
    repeat (5) begin
      tick();
      check("t3_wait_busy", 32'(busy), 32'd1);
      check("t3_wait_grant", 32'(grant), 32'd0);
    end
    rdy = 1'b0;
    tick();
    check("t3_idle", 32'(busy), 32'd0);

    // 4: watchdog revokes core 2 after 8 cycles, then core 3 is served
    apply_reset();
    rq = 4'b1100;
    push(4'b0100, 2'd2);
    wait_grant(1);
    n = 0;
    while (grant == 4'b0100 && n < 20) begin
      n++;
      tick();
    end
    check("t4_hold_cycles", 32'(n), 32'd8);
    check("t4_pulse", 32'(tpulse), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    tick();
    check("t4_pulse_end", 32'(tpulse), 32'd0);
    push(4'b1000, 2'd3);
    wait_grant(1);
    // release coinciding with the watchdog limit: no pulse
    repeat (7) begin
      tick();
      check("t4_hold3", 32'(grant), 32'd8);
    end
    rq = 4'b0100;
    tick();
    check("t4_sim_release", 32'(grant), 32'd0);
    check("t4_sim_nopulse", 32'(tpulse), 32'd0);
    push(4'b0100, 2'd2);
    wait_grant(2);

    // 5: asynchronous reset mid-grant
    #2 reset = 1'b1;
    #1;
    check("t5_async_grant", 32'(grant), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_owner", 32'(owner), 32'd0);
    rq = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    push(4'b0001, 2'd0);
    wait_grant(1);

    // 6: wrap and priority with rq=1001
    apply_reset();
    rq = 4'b1001;
    push(4'b0001, 2'd0);
    wait_grant(1);
    rq = 4'b0000;
    tick();
    rq = 4'b1001;
    push(4'b1000, 2'd3);
    wait_grant(2);
    rq = 4'b0000;
    tick();
    check("t6_owner_held", 32'(owner), 32'd3);
    rq = 4'b1001;
    push(4'b0001, 2'd0);
    wait_grant(2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
